clock_set_ctrl: RTL and testbench

Time-set front end for the mm:ss display clock. It debounces three raw push-buttons and runs an edit state machine. The timekeeper's current minutes and seconds are captured, the user edits them, and the result is written back through a one-cycle load strobe. It also freezes the timekeeper during editing and drives a per-digit blink mask to the display multiplexer.

---
 rtl/clock_set_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Time-set front end for the mm:ss clock: button debounce,
// edit FSM, timekeeper freeze/load and per-digit blink mask.
module clock_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES    = 12_500_000
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       load,
    output logic       run_en,
    output logic [3:0] blank_sel,
    output logic [1:0] mode
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BL_LAST = BW'(BLINK_CYCLES - 1);

    localparam logic [1:0] RUN     = 2'b00;
    localparam logic [1:0] SET_MIN = 2'b01;
    localparam logic [1:0] SET_SEC = 2'b10;

    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    stable;
    logic [2:0]    stable_d;
    logic [2:0]    press;
    logic [DW-1:0] db_cnt [3];

    logic          p_mode;
    logic          p_inc;
    logic          p_dec;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [BW-1:0] blink_cnt;
    logic          phase;

    assign raw = {btn_dec, btn_inc, btn_mode};

    // Two-flop synchronizers and the one-cycle delayed accepted level
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable_d <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
        end
    end

    // Accept a new level only after it persists for DEBOUNCE_CYCLES cycles
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            stable <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        stable[i] <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign press  = stable & ~stable_d;
    assign p_mode = press[0];
    assign p_inc  = press[1];
    assign p_dec  = press[2];

    // Modulo-60 step; simultaneous inc and dec cancel out
    function automatic logic [5:0] step60(
        input logic [5:0] v,
        input logic       up,
        input logic       dn
    );
        logic [5:0] r;
        r = v;
        if (up && !dn) begin
            r = (v == 6'd59) ? 6'd0 : v + 6'd1;
        end else if (dn && !up) begin
            r = (v == 6'd0) ? 6'd59 : v - 6'd1;
        end
        return r;
    endfunction

    // Mode button cycles RUN -> SET_MIN -> SET_SEC -> RUN
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (p_mode) state_nxt = SET_MIN;
            SET_MIN: if (p_mode) state_nxt = SET_SEC;
            SET_SEC: if (p_mode) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Edit datapath: capture on entry, step while editing, load on exit
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state   <= RUN;
            set_min <= '0;
            set_sec <= '0;
            load    <= 1'b0;
            run_en  <= 1'b1;
        end else begin
            state  <= state_nxt;
            load   <= 1'b0;
            run_en <= (state_nxt == RUN);
            case (state)
                RUN: begin
                    if (p_mode) begin
                        set_min <= cur_min;
                        set_sec <= cur_sec;
                    end
                end
                SET_MIN: begin
                    if (!p_mode) begin
                        set_min <= step60(set_min, p_inc, p_dec);
                    end
                end
                SET_SEC: begin
                    if (p_mode) begin
                        load <= 1'b1;
                    end else begin
                        set_sec <= step60(set_sec, p_inc, p_dec);
                    end
                end
                default: ;
            endcase
        end
    end

    // Blink phase generator, restarted visible on every state entry
    always_ff @(posedge sys_clk) begin
        if (rst || (state_nxt != state)) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (state != RUN) begin
            if (blink_cnt == BL_LAST) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // Blank mask decoded from registers only
    always_comb begin
        blank_sel = 4'b0000;
        case (state)
            SET_MIN: blank_sel = {phase, phase, 2'b00};
            SET_SEC: blank_sel = {2'b00, phase, phase};
            default: blank_sel = 4'b0000;
        endcase
    end

    assign mode = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: behavioural model compared every cycle
// plus directed literal expectations.
module tb_clock_set_ctrl;

    localparam int DEB = 4;
    localparam int BLK = 3;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic [5:0] cur_min = 6'd0;
    logic [5:0] cur_sec = 6'd0;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       load;
    logic       run_en;
    logic [3:0] blank_sel;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;

    clock_set_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .BLINK_CYCLES(BLK)
    ) dut (
        .sys_clk(sys_clk),
        .rst(rst),
        .btn_mode(btn_mode),
        .btn_inc(btn_inc),
        .btn_dec(btn_dec),
        .cur_min(cur_min),
        .cur_sec(cur_sec),
        .set_min(set_min),
        .set_sec(set_sec),
        .load(load),
        .run_en(run_en),
        .blank_sel(blank_sel),
        .mode(mode)
    );

    always #5 sys_clk = ~sys_clk;

    // ---------------- behavioural model ----------------
    bit [2:0] m_s1, m_s2, m_acc, m_press;
    int       m_run [3];
    int       m_mode, m_min, m_sec, m_t;
    bit       m_load;
    bit       m_valid = 1'b0;

    function automatic int wrap_step(int v, bit up, bit dn);
        if (up && !dn) return (v + 1) % 60;
        if (dn && !up) return (v + 59) % 60;
        return v;
    endfunction

    function automatic logic [3:0] exp_blank();
        int ph;
        ph = (m_t / BLK) % 2;
        if (m_mode == 1) return (ph != 0) ? 4'b1100 : 4'b0000;
        if (m_mode == 2) return (ph != 0) ? 4'b0011 : 4'b0000;
        return 4'b0000;
    endfunction

    always @(posedge sys_clk) begin
        bit [2:0] raw;
        bit       old;
        int       prev_mode;
        raw = {btn_dec, btn_inc, btn_mode};
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_acc = '0; m_press = '0;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
            m_mode = 0; m_min = 0; m_sec = 0; m_t = 0; m_load = 0;
            m_valid = 1'b1;
        end else begin
            prev_mode = m_mode;
            m_load = 0;
            if (m_press[0]) begin
                case (m_mode)
                    0: begin m_min = cur_min; m_sec = cur_sec; m_mode = 1; end
                    1: m_mode = 2;
                    default: begin m_mode = 0; m_load = 1; end
                endcase
            end else if (m_mode == 1) begin
                m_min = wrap_step(m_min, m_press[1], m_press[2]);
            end else if (m_mode == 2) begin
                m_sec = wrap_step(m_sec, m_press[1], m_press[2]);
            end
            if (m_mode != prev_mode) m_t = 0;
            else m_t = m_t + 1;
            // a level is accepted after DEB consecutive differing samples
            for (int i = 0; i < 3; i++) begin
                old = m_acc[i];
                if (m_s2[i] != m_acc[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DEB) begin
                        m_acc[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_press[i] = m_acc[i] & ~old;
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge sys_clk) begin
        if (m_valid) begin
            checks++;
            if (mode !== 2'(m_mode) || set_min !== 6'(m_min) ||
                set_sec !== 6'(m_sec) || load !== m_load ||
                run_en !== (m_mode == 0) || blank_sel !== exp_blank()) begin
                errors++;
                $display("FAIL model t=%0t act mode=%0d min=%0d sec=%0d load=%b run=%b blank=%b exp mode=%0d min=%0d sec=%0d load=%b run=%b blank=%b",
                         $time, mode, set_min, set_sec, load, run_en, blank_sel,
                         m_mode, m_min, m_sec, m_load, (m_mode == 0), exp_blank());
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic set_btn(int b, logic v);
        case (b)
            0: btn_mode = v;
            1: btn_inc = v;
            default: btn_dec = v;
        endcase
    endtask

    task automatic press(int b);
        set_btn(b, 1'b1);
        cyc(DEB + 4);
        set_btn(b, 1'b0);
        cyc(DEB + 4);
    endtask

    // Hold mode, verify exact latency, then sample the blink pattern
    task automatic enter_check(int from_m, int to_m, logic [3:0] hi);
        logic [3:0] e;
        btn_mode = 1'b1;
        repeat (DEB + 2) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("mode_latency_early", mode, from_m);
        @(negedge sys_clk);
        chk("mode_latency_edge", mode, to_m);
        chk("entry_blank", blank_sel, 0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge sys_clk);
            e = ((k / BLK) % 2 != 0) ? hi : 4'b0000;
            chk("blink", blank_sel, e);
        end
        btn_mode = 1'b0;
        cyc(DEB + 4);
    endtask

    int loads;

    initial begin
        cur_min = 6'd12;
        cur_sec = 6'd34;
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        chk("rst_mode", mode, 0);
        chk("rst_run_en", run_en, 1);
        chk("rst_blank", blank_sel, 0);
        chk("rst_set_min", set_min, 0);
        chk("rst_set_sec", set_sec, 0);
        chk("rst_load", load, 0);
        cyc(2);

        enter_check(0, 1, 4'b1100);
        chk("cap_min", set_min, 12);
        chk("cap_sec", set_sec, 34);
        chk("cap_run_en", run_en, 0);
        chk("cap_load", load, 0);
        cur_min = 6'd5;
        cur_sec = 6'd6;

        btn_inc = 1'b1;
        cyc(2);
        btn_inc = 1'b0;
        cyc(12);
        chk("glitch_min", set_min, 12);

        repeat (12) press(2);
        chk("dec_to_zero", set_min, 0);
        press(2);
        chk("min_dec_wrap", set_min, 59);
        press(1);
        chk("min_inc_wrap", set_min, 0);

        btn_inc = 1'b1;
        btn_dec = 1'b1;
        cyc(DEB + 4);
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        cyc(DEB + 4);
        chk("inc_dec_same", set_min, 0);

        enter_check(1, 2, 4'b0011);
        chk("sec_kept", set_sec, 34);
        repeat (34) press(2);
        chk("sec_zero", set_sec, 0);
        press(2);
        chk("sec_dec_wrap", set_sec, 59);
        press(1);
        chk("sec_inc_wrap", set_sec, 0);
        press(1);
        chk("sec_one", set_sec, 1);

        loads = 0;
        btn_mode = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge sys_clk);
            if (load) begin
                loads++;
                chk("commit_min", set_min, 0);
                chk("commit_sec", set_sec, 1);
                chk("commit_mode", mode, 0);
                chk("commit_run_en", run_en, 1);
                chk("commit_blank", blank_sel, 0);
            end
        end
        chk("load_count", loads, 1);
        btn_mode = 1'b0;
        cyc(DEB + 4);

        press(0);
        chk("re_cap_min", set_min, 5);
        press(0);
        press(1);
        chk("pre_rst_mode", mode, 2);
        chk("pre_rst_sec", set_sec, 7);
        loads = 0;
        rst = 1'b1;
        @(negedge sys_clk);
        chk("mid_rst_mode", mode, 0);
        chk("mid_rst_run_en", run_en, 1);
        chk("mid_rst_min", set_min, 0);
        chk("mid_rst_sec", set_sec, 0);
        for (int k = 0; k < 12; k++) begin
            if (k == 2) rst = 1'b0;
            if (load) loads++;
            @(negedge sys_clk);
        end
        chk("mid_rst_no_load", loads, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
